// File: rtl/cpu_state_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_state_sequencer
//
// Multi-cycle state sequencer for the MIPS core. It produces the 4-bit state
// code that the control unit decodes:
//   0 = HALT, 1 = FETCH, 2 = DECODE, 3 = EXEC1, 4 = EXEC2.
// FETCH, EXEC1 (memory ops) and EXEC2 are stretched while the Avalon memory
// asserts waitrequest. The sequencer halts once an instruction retires with
// a next PC of zero. It also keeps cycle, retired-instruction and stall
// counters for debug.
//
// Optional feature macro: MULTDIV_INTERLOCK_EN
//   When defined, EXEC1 is held while an MFHI/MFLO waits on a busy
//   mult/div unit. When undefined, div_mult_busy and fun are ignored.
//
// Parameters
//   COUNT_W        width of the cycle/instruction/stall counters
//
// Ports
//   clk            core clock, rising edge
//   reset          asynchronous, active-high reset
//   waitrequest    Avalon stall from memory
//   opcode         instruction bits 31:26
//   fun            instruction bits 5:0
//   pc_next        value the PC loads on this cycle's pcwrite
//   div_mult_busy  mult/div unit still computing HI/LO
//   state          current sequencer state code
//   active         high whenever state != HALT
//   cycle_count    cycles spent with active high
//   instr_count    instructions retired (EXEC2 exits)
//   stall_count    cycles in which the state was held by a stall
// ---------------------------------------------------------------------------
module cpu_state_sequencer #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               waitrequest,
    input  logic [5:0]         opcode,
    input  logic [5:0]         fun,
    input  logic [31:0]        pc_next,
    input  logic               div_mult_busy,
    output logic [3:0]         state,
    output logic               active,
    output logic [COUNT_W-1:0] cycle_count,
    output logic [COUNT_W-1:0] instr_count,
    output logic [COUNT_W-1:0] stall_count
);

    localparam logic [3:0] S_HALT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EXEC1  = 4'd3;
    localparam logic [3:0] S_EXEC2  = 4'd4;

    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_LUI_P  = 6'b011111;

    logic [3:0]         state_q, state_d;
    logic               booted_q, booted_d;
    logic [COUNT_W-1:0] cycle_q, cycle_d;
    logic [COUNT_W-1:0] instr_q, instr_d;
    logic [COUNT_W-1:0] stall_q, stall_d;

    logic               mem_ex1;
    logic               interlock;
    logic               stall_hold;
    logic               retire;

    assign mem_ex1 = (opcode == OP_LW) || (opcode == OP_LUI_P);

`ifdef MULTDIV_INTERLOCK_EN
    // MFHI/MFLO must not read HI/LO before the mult/div unit finishes.
    // Holding EXEC1 is safe because div_mult_en is never raised for them.
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MFLO    = 6'b010010;

    assign interlock = (opcode == OP_SPECIAL) &&
                       ((fun == FN_MFHI) || (fun == FN_MFLO)) &&
                       div_mult_busy;
`else
    // Software spaces MFHI/MFLO after MULT/DIV, so these inputs are unused.
    logic unused_interlock_inputs;
    assign unused_interlock_inputs = ^{fun, div_mult_busy};
    assign interlock = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        booted_d   = booted_q;
        stall_hold = 1'b0;
        retire     = 1'b0;
        case (state_q)
            S_HALT: begin
                // Only the first HALT after reset boots; a later HALT is final.
                if (!booted_q) begin
                    state_d  = S_FETCH;
                    booted_d = 1'b1;
                end
            end
            S_FETCH: begin
                if (waitrequest) begin
                    stall_hold = 1'b1;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC1;
            end
            S_EXEC1: begin
                // Both stall sources together still count as a single cycle.
                if ((mem_ex1 && waitrequest) || interlock) begin
                    stall_hold = 1'b1;
                end else begin
                    state_d = S_EXEC2;
                end
            end
            S_EXEC2: begin
                if (waitrequest) begin
                    stall_hold = 1'b1;
                end else begin
                    retire  = 1'b1;
                    state_d = (pc_next == 32'd0) ? S_HALT : S_FETCH;
                end
            end
            default: begin
                // Unused codes are reachable only by upset: park in HALT for good.
                state_d  = S_HALT;
                booted_d = 1'b1;
            end
        endcase
    end

    assign active = (state_q != S_HALT);

    always_comb begin
        cycle_d = cycle_q;
        instr_d = instr_q;
        stall_d = stall_q;
        if (active) begin
            cycle_d = cycle_q + 1'b1;
        end
        if (retire) begin
            instr_d = instr_q + 1'b1;
        end
        if (stall_hold) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_HALT;
            booted_q <= 1'b0;
            cycle_q  <= '0;
            instr_q  <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            booted_q <= booted_d;
            cycle_q  <= cycle_d;
            instr_q  <= instr_d;
            stall_q  <= stall_d;
        end
    end

    assign state       = state_q;
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_cpu_state_sequencer.sv
module tb_cpu_state_sequencer;

    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LUIP  = 6'b011111;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        waitrequest = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  fun = '0;
    logic [31:0] pc_next = 32'd4;
    logic        div_mult_busy = 1'b0;

    logic [3:0]  state;
    logic        active;
    logic [31:0] cycle_count, instr_count, stall_count;

    logic [3:0]  state4;
    logic        active4;
    logic [3:0]  cycle4, instr4, stall4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_state_sequencer dut (
        .clk(clk), .reset(reset), .waitrequest(waitrequest),
        .opcode(opcode), .fun(fun), .pc_next(pc_next),
        .div_mult_busy(div_mult_busy),
        .state(state), .active(active),
        .cycle_count(cycle_count), .instr_count(instr_count),
        .stall_count(stall_count)
    );

    cpu_state_sequencer #(.COUNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .waitrequest(waitrequest),
        .opcode(opcode), .fun(fun), .pc_next(pc_next),
        .div_mult_busy(div_mult_busy),
        .state(state4), .active(active4),
        .cycle_count(cycle4), .instr_count(instr4),
        .stall_count(stall4)
    );

    typedef struct {
        logic        wr;
        logic [5:0]  op;
        logic [31:0] pc;
        logic [3:0]  st;
        int unsigned ic;
        int unsigned cc;
        int unsigned sc;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] st, input int unsigned ic,
                           input int unsigned cc, input int unsigned sc);
        chk({tag, ".state"}, {28'd0, state}, {28'd0, st});
        chk({tag, ".active"}, {31'd0, active}, {31'd0, (st != 4'd0)});
        chk({tag, ".instr"}, instr_count, ic);
        chk({tag, ".cycle"}, cycle_count, cc);
        chk({tag, ".stall"}, stall_count, sc);
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic wr, input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] pc, input logic busy);
        waitrequest   = wr;
        opcode        = op;
        fun           = fn;
        pc_next       = pc;
        div_mult_busy = busy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        waitrequest = 1'b0;
        div_mult_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // cycle-by-cycle vectors starting at the boot edge after reset
        tbl[0]  = '{1'b0, OP_ADDIU, 32'd4, 4'd1, 0, 0,  0};
        tbl[1]  = '{1'b0, OP_ADDIU, 32'd4, 4'd2, 0, 1,  0};
        tbl[2]  = '{1'b0, OP_ADDIU, 32'd4, 4'd3, 0, 2,  0};
        tbl[3]  = '{1'b0, OP_ADDIU, 32'd4, 4'd4, 0, 3,  0};
        tbl[4]  = '{1'b0, OP_ADDIU, 32'd4, 4'd1, 1, 4,  0};
        tbl[5]  = '{1'b1, OP_LW,    32'd8, 4'd1, 1, 5,  1};
        tbl[6]  = '{1'b1, OP_LW,    32'd8, 4'd1, 1, 6,  2};
        tbl[7]  = '{1'b1, OP_LW,    32'd8, 4'd1, 1, 7,  3};
        tbl[8]  = '{1'b0, OP_LW,    32'd8, 4'd2, 1, 8,  3};
        tbl[9]  = '{1'b1, OP_LW,    32'd8, 4'd3, 1, 9,  3};
        tbl[10] = '{1'b1, OP_LW,    32'd8, 4'd3, 1, 10, 4};
        tbl[11] = '{1'b1, OP_LW,    32'd8, 4'd3, 1, 11, 5};
        tbl[12] = '{1'b0, OP_LW,    32'd8, 4'd4, 1, 12, 5};
        tbl[13] = '{1'b0, OP_LW,    32'd8, 4'd1, 2, 13, 5};
        tbl[14] = '{1'b0, OP_ADDIU, 32'd0, 4'd2, 2, 14, 5};
        tbl[15] = '{1'b0, OP_ADDIU, 32'd0, 4'd3, 2, 15, 5};
        tbl[16] = '{1'b1, OP_ADDIU, 32'd0, 4'd4, 2, 16, 5};
        tbl[17] = '{1'b1, OP_ADDIU, 32'd0, 4'd4, 2, 17, 6};
        tbl[18] = '{1'b0, OP_ADDIU, 32'd0, 4'd0, 3, 18, 6};
        tbl[19] = '{1'b0, OP_ADDIU, 32'd4, 4'd0, 3, 18, 6};
        tbl[20] = '{1'b0, OP_ADDIU, 32'd4, 4'd0, 3, 18, 6};

        // reset state, before any clock edge
        #2;
        chk_all("reset", 4'd0, 0, 0, 0);

        // ADDIU, LW with stalls, EXEC2 stall, halt on pc_next==0
        do_reset();
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].wr, tbl[i].op, 6'd0, tbl[i].pc, 1'b0);
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].ic, tbl[i].cc, tbl[i].sc);
        end

        // reset asserted mid-EXEC1 of an LW clears outputs without a clock edge
        do_reset();
        step(1'b0, OP_LW, 6'd0, 32'd4, 1'b0);
        step(1'b0, OP_LW, 6'd0, 32'd4, 1'b0);
        step(1'b1, OP_LW, 6'd0, 32'd4, 1'b0);
        step(1'b1, OP_LW, 6'd0, 32'd4, 1'b0);
        chk_all("pre_rst", 4'd3, 0, 3, 1);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 4'd0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, OP_LW, 6'd0, 32'd4, 1'b0);
        chk_all("rst_boot", 4'd1, 0, 0, 0);

        // MFLO with mult/div busy for 10 cycles
        do_reset();
        step(1'b0, 6'd0, FN_MFLO, 32'd4, 1'b0);
        step(1'b0, 6'd0, FN_MFLO, 32'd4, 1'b0);
        step(1'b0, 6'd0, FN_MFLO, 32'd4, 1'b1);
        chk_all("mflo_ex1", 4'd3, 0, 2, 0);
`ifdef MULTDIV_INTERLOCK_EN
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 6'd0, FN_MFLO, 32'd4, 1'b1);
            chk({"mflo_hold.state"}, {28'd0, state}, 32'd3);
        end
        step(1'b0, 6'd0, FN_MFLO, 32'd4, 1'b0);
        chk_all("mflo_done", 4'd4, 0, 13, 10);
        step(1'b0, 6'd0, FN_MFLO, 32'd4, 1'b0);
        chk_all("mflo_ret", 4'd1, 1, 14, 10);
`else
        step(1'b0, 6'd0, FN_MFLO, 32'd4, 1'b1);
        chk_all("mflo_done", 4'd4, 0, 3, 0);
        step(1'b0, 6'd0, FN_MFLO, 32'd4, 1'b1);
        chk_all("mflo_ret", 4'd1, 1, 4, 0);
`endif

        // LUI-path opcode also stalls EXEC1 on waitrequest
        do_reset();
        step(1'b0, OP_LUIP, 6'd0, 32'd4, 1'b0);
        step(1'b0, OP_LUIP, 6'd0, 32'd4, 1'b0);
        step(1'b0, OP_LUIP, 6'd0, 32'd4, 1'b0);
        step(1'b1, OP_LUIP, 6'd0, 32'd4, 1'b0);
        chk_all("lui_hold", 4'd3, 0, 3, 1);
        step(1'b0, OP_LUIP, 6'd0, 32'd4, 1'b0);
        chk_all("lui_ex2", 4'd4, 0, 4, 1);

        // 4-bit counter instance wraps 15 -> 0 while sequencing continues
        do_reset();
        for (int k = 1; k <= 21; k++) begin
            step(1'b0, OP_ADDIU, 6'd0, 32'd4, 1'b0);
            chk($sformatf("wrap%0d.state4", k), {28'd0, state4}, ((k - 1) % 4) + 1);
            chk($sformatf("wrap%0d.cycle", k), cycle_count, k - 1);
            if (k == 16) chk("wrap16.cycle4", {28'd0, cycle4}, 32'd15);
            if (k == 17) chk("wrap17.cycle4", {28'd0, cycle4}, 32'd0);
        end
        chk("wrap.cycle4_final", {28'd0, cycle4}, 32'd4);
        chk("wrap.instr4_final", {28'd0, instr4}, 32'd5);
        chk("wrap.active4", {31'd0, active4}, 32'd1);
        chk("wrap.stall4", {28'd0, stall4}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
